ibex_register_file_mp: RTL and testbench

Parametrised multi-port flip-flop register file for Ibex-class cores. It provides N read ports, M prioritised write ports, optional same-cycle write bypass, write-collision detection and a sequential secure-wipe engine. It sits in the ID stage in place of the single-write-port FF register file and serves dual-issue or writeback-merged pipelines. R0 stays hard-wired to `WordZeroVal`.

---
 rtl/ibex_rf_pkg.sv | 20 ++
 rtl/ibex_register_file_mp_if.sv | 40 ++++
 rtl/ibex_rf_wipe_fsm.sv | 80 ++++++++
 rtl/ibex_register_file_mp.sv | 138 +++++++++++++
 tb/tb_ibex_register_file_mp.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_rf_pkg.sv
// ibex_rf_pkg
// Shared types and helpers for the multi-port register file.
//   rf_wipe_state_e : states of the secure-wipe engine
//   RF_ADDR_W       : architectural register address width
//   rf_num_words()  : number of architectural registers for a given RV32E setting
package ibex_rf_pkg;

   localparam int RF_ADDR_W = 5;

   typedef enum logic [1:0] {
      RF_IDLE = 2'd0,
      RF_WIPE = 2'd1,
      RF_DONE = 2'd2
   } rf_wipe_state_e;

   function automatic int unsigned rf_num_words(input bit rv32e);
      return rv32e ? 32'd16 : 32'd32;
   endfunction

endpackage

// File: rtl/ibex_register_file_mp_if.sv
// ibex_register_file_mp_if
// Bundles the register-file access signals.
//   master : the pipeline side (drives addresses, write data/enables, wipe request)
//   slave  : the register file (drives read data, wipe status, collision flag)
//
// Access contract: there is no valid/ready handshake. Read data is a
// combinational function of raddr_i and the current register contents, and is
// valid in the same cycle the address is presented. A write with we_i high is
// committed at the next rising clk edge, unless wipe_busy_o is high in that
// cycle, in which case it is dropped. wipe_req_i is a level, sampled only while
// the wipe engine is idle. dbg_wipe_state mirrors the wipe engine state.
interface ibex_register_file_mp_if #(
   parameter int NumReadPorts  = 2,
   parameter int NumWritePorts = 1,
   parameter int DataWidth     = 32
);
   import ibex_rf_pkg::*;

   logic [NumReadPorts-1:0][RF_ADDR_W-1:0]  raddr_i;
   logic [NumReadPorts-1:0][DataWidth-1:0]  rdata_o;
   logic [NumWritePorts-1:0][RF_ADDR_W-1:0] waddr_i;
   logic [NumWritePorts-1:0][DataWidth-1:0] wdata_i;
   logic [NumWritePorts-1:0]                we_i;
   logic                                    wipe_req_i;
   logic                                    wipe_busy_o;
   logic                                    wipe_done_o;
   logic                                    err_o;
   rf_wipe_state_e                          dbg_wipe_state;

   modport master (
      output raddr_i, waddr_i, wdata_i, we_i, wipe_req_i,
      input  rdata_o, wipe_busy_o, wipe_done_o, err_o, dbg_wipe_state
   );

   modport slave (
      input  raddr_i, waddr_i, wdata_i, we_i, wipe_req_i,
      output rdata_o, wipe_busy_o, wipe_done_o, err_o, dbg_wipe_state
   );

endinterface

// File: rtl/ibex_rf_wipe_fsm.sv
// ibex_rf_wipe_fsm
// Sequential secure-wipe engine. Walks registers 1..NumWords-1, one per cycle,
// then pulses wipe_done_o for one cycle.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   wipe_req_i    : start request, sampled in RF_IDLE only
//   wipe_we       : write strobe for the register addressed by wipe_addr
//   wipe_addr     : register currently being wiped
//   wipe_busy_o   : high while in RF_WIPE
//   wipe_done_o   : one-cycle completion pulse (RF_DONE)
//   state_o       : current state, for observation
module ibex_rf_wipe_fsm
   import ibex_rf_pkg::*;
#(
   parameter int unsigned NumWords = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wipe_req_i,
   output logic                 wipe_we,
   output logic [RF_ADDR_W-1:0] wipe_addr,
   output logic                 wipe_busy_o,
   output logic                 wipe_done_o,
   output rf_wipe_state_e       state_o
);

   localparam logic [RF_ADDR_W-1:0] LastAddr = RF_ADDR_W'(NumWords - 1);

   rf_wipe_state_e       state_q;
   logic [RF_ADDR_W-1:0] cnt_q;
   logic                 busy_q;
   logic                 done_q;

   // busy_q/done_q are updated alongside state_q so they always equal
   // (state_q == RF_WIPE) and (state_q == RF_DONE) respectively.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RF_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            RF_IDLE: begin
               done_q <= 1'b0;
               if (wipe_req_i) begin
                  state_q <= RF_WIPE;
                  cnt_q   <= RF_ADDR_W'(1);
                  busy_q  <= 1'b1;
               end
            end
            RF_WIPE: begin
               // The last register is still written in this cycle.
               if (cnt_q == LastAddr) begin
                  state_q <= RF_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + RF_ADDR_W'(1);
               end
            end
            RF_DONE: begin
               state_q <= RF_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= RF_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign wipe_we     = busy_q;
   assign wipe_addr   = cnt_q;
   assign wipe_busy_o = busy_q;
   assign wipe_done_o = done_q;
   assign state_o     = state_q;

endmodule

// File: rtl/ibex_register_file_mp.sv
// ibex_register_file_mp
// Multi-port flip-flop register file: NumReadPorts combinational read ports,
// NumWritePorts prioritised write ports (highest index wins), write-collision
// flag and a sequential secure wipe. R0 has no storage and reads WordZeroVal.
//   clk_i : clock
//   rst_i : synchronous active-high reset
//   rf    : ibex_register_file_mp_if.slave (addresses, data, enables,
//           wipe request/busy/done, err_o, wipe state)
// Build option: IBEX_RF_WRITE_BYPASS_EN forwards same-cycle write data to
// matching read ports; without it reads see registered contents only.
module ibex_register_file_mp
   import ibex_rf_pkg::*;
#(
   parameter bit                    RV32E         = 1'b0,
   parameter int                    DataWidth     = 32,
   parameter int                    NumReadPorts  = 2,
   parameter int                    NumWritePorts = 1,
   parameter logic [DataWidth-1:0]  WordResetVal  = '0,
   parameter logic [DataWidth-1:0]  WordZeroVal   = '0
) (
   input logic                   clk_i,
   input logic                   rst_i,
   ibex_register_file_mp_if.slave rf
);

   localparam int unsigned          NumWords = rf_num_words(RV32E);
   // RV32E ignores address bit 4 on every port.
   localparam logic [RF_ADDR_W-1:0] AddrMask = RV32E ? 5'h0F : 5'h1F;

   logic                 wipe_we;
   logic [RF_ADDR_W-1:0] wipe_addr;
   logic                 wipe_busy;
   logic                 wipe_done;
   rf_wipe_state_e       wipe_state;

   ibex_rf_wipe_fsm #(
      .NumWords (NumWords)
   ) u_wipe_fsm (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .wipe_req_i  (rf.wipe_req_i),
      .wipe_we     (wipe_we),
      .wipe_addr   (wipe_addr),
      .wipe_busy_o (wipe_busy),
      .wipe_done_o (wipe_done),
      .state_o     (wipe_state)
   );

   // Effective write requests: masked by wipe and by address 0.
   logic [NumWritePorts-1:0][RF_ADDR_W-1:0] waddr_eff;
   logic [NumWritePorts-1:0]                we_eff;

   always_comb begin
      for (int p = 0; p < NumWritePorts; p++) begin
         waddr_eff[p] = rf.waddr_i[p] & AddrMask;
         we_eff[p]    = rf.we_i[p] & ~wipe_busy & (waddr_eff[p] != '0);
      end
   end

   // Storage for registers 1..NumWords-1 only.
   logic [DataWidth-1:0] rf_q [NumWords-1:1];
   logic [DataWidth-1:0] rf_d [NumWords-1:1];

   always_comb begin
      for (int i = 1; i < NumWords; i++) begin
         rf_d[i] = rf_q[i];
         // Later ports overwrite earlier ones: highest index wins.
         for (int p = 0; p < NumWritePorts; p++) begin
            if (we_eff[p] && (waddr_eff[p] == RF_ADDR_W'(i))) begin
               rf_d[i] = rf.wdata_i[p];
            end
         end
         if (wipe_we && (wipe_addr == RF_ADDR_W'(i))) begin
            rf_d[i] = WordResetVal;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 1; i < NumWords; i++) rf_q[i] <= WordResetVal;
      end else begin
         for (int i = 1; i < NumWords; i++) rf_q[i] <= rf_d[i];
      end
   end

   // Full 32-entry read view so any 5-bit index is in range; entry 0 and any
   // entries beyond NumWords read as WordZeroVal.
   logic [DataWidth-1:0] rf_view [32];

   always_comb begin
      for (int i = 0; i < 32; i++) rf_view[i] = WordZeroVal;
      for (int i = 1; i < NumWords; i++) rf_view[i] = rf_q[i];
   end

   logic [NumReadPorts-1:0][DataWidth-1:0] rdata;
   logic [NumReadPorts-1:0][RF_ADDR_W-1:0] raddr_eff;

   always_comb begin
      for (int r = 0; r < NumReadPorts; r++) begin
         raddr_eff[r] = rf.raddr_i[r] & AddrMask;
         rdata[r]     = rf_view[raddr_eff[r]];
`ifdef IBEX_RF_WRITE_BYPASS_EN
         // we_eff already excludes address 0 and wipe cycles.
         for (int p = 0; p < NumWritePorts; p++) begin
            if (we_eff[p] && (waddr_eff[p] == raddr_eff[r])) begin
               rdata[r] = rf.wdata_i[p];
            end
         end
`endif
      end
   end

   // Collision: two enabled writes to the same nonzero register.
   logic coll;
   logic err_q;

   always_comb begin
      coll = 1'b0;
      for (int a = 0; a < NumWritePorts; a++) begin
         for (int b = a + 1; b < NumWritePorts; b++) begin
            if (we_eff[a] && we_eff[b] && (waddr_eff[a] == waddr_eff[b])) coll = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) err_q <= 1'b0;
      else       err_q <= coll;
   end

   assign rf.rdata_o        = rdata;
   assign rf.err_o          = err_q;
   assign rf.wipe_busy_o    = wipe_busy;
   assign rf.wipe_done_o    = wipe_done;
   assign rf.dbg_wipe_state = wipe_state;

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// tb_ibex_register_file_mp
// Scoreboard bench for ibex_register_file_mp (2 read / 2 write ports). A
// driver applies one cycle of stimulus at a time and pushes the expected
// outputs from a reference model; a monitor pops and compares at the falling
// edge. A second RV32E instance is exercised with directed checks.
module tb_ibex_register_file_mp;

   localparam int DW    = 32;
   localparam int NW    = 32;
   localparam int EXP_W = 2 * DW + 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_e = 1'b1;

   always #5 clk = ~clk;

   ibex_register_file_mp_if #(.NumReadPorts(2), .NumWritePorts(2), .DataWidth(DW)) bus ();
   ibex_register_file_mp_if #(.NumReadPorts(2), .NumWritePorts(2), .DataWidth(DW)) bus_e ();

   ibex_register_file_mp #(
      .RV32E(1'b0), .DataWidth(DW), .NumReadPorts(2), .NumWritePorts(2)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .rf    (bus.slave)
   );

   ibex_register_file_mp #(
      .RV32E(1'b1), .DataWidth(DW), .NumReadPorts(2), .NumWritePorts(2)
   ) dut_e (
      .clk_i (clk),
      .rst_i (rst_e),
      .rf    (bus_e.slave)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [EXP_W-1:0] exp_q[$];

   // Reference model: architectural register contents, pending error flag and
   // wipe position (0 idle, 1..NW-1 wiping register k, NW done pulse).
   logic [DW-1:0] m_rf [NW];
   bit            m_err;
   int            m_pos;

   function automatic logic [DW-1:0] exp_read(input logic [4:0] a, input bit busy,
                                              input bit we0, input logic [4:0] wa0, input logic [DW-1:0] wd0,
                                              input bit we1, input logic [4:0] wa1, input logic [DW-1:0] wd1);
      logic [DW-1:0] v;
      v = (a == 5'd0) ? '0 : m_rf[a];
`ifdef IBEX_RF_WRITE_BYPASS_EN
      if (!busy && a != 5'd0) begin
         if (we0 && wa0 == a) v = wd0;
         if (we1 && wa1 == a) v = wd1;
      end
`endif
      return v;
   endfunction

   task automatic step(input bit r, input logic [4:0] ra0, input logic [4:0] ra1,
                       input bit we0, input logic [4:0] wa0, input logic [DW-1:0] wd0,
                       input bit we1, input logic [4:0] wa1, input logic [DW-1:0] wd1,
                       input bit req, input bit chk);
      bit busy, done;
      logic [DW-1:0] rd0, rd1;
      rst = r;
      bus.raddr_i[0] = ra0;  bus.raddr_i[1] = ra1;
      bus.we_i       = {we1, we0};
      bus.waddr_i[0] = wa0;  bus.waddr_i[1] = wa1;
      bus.wdata_i[0] = wd0;  bus.wdata_i[1] = wd1;
      bus.wipe_req_i = req;
      busy = (m_pos >= 1) && (m_pos <= NW - 1);
      done = (m_pos == NW);
      rd0 = exp_read(ra0, busy, we0, wa0, wd0, we1, wa1, wd1);
      rd1 = exp_read(ra1, busy, we0, wa0, wd0, we1, wa1, wd1);
      if (chk) exp_q.push_back({rd0, rd1, m_err, busy, done});
      if (r) begin
         for (int i = 0; i < NW; i++) m_rf[i] = '0;
         m_err = 0;
         m_pos = 0;
      end else begin
         m_err = !busy && we0 && we1 && (wa0 == wa1) && (wa0 != 5'd0);
         if (busy) m_rf[m_pos] = '0;
         else begin
            if (we0 && wa0 != 5'd0) m_rf[wa0] = wd0;
            if (we1 && wa1 != 5'd0) m_rf[wa1] = wd1;
         end
         if (done)      m_pos = 0;
         else if (busy) m_pos++;
         else if (req)  m_pos = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_read(input logic [4:0] ra0, input logic [4:0] ra1);
      step(0, ra0, ra1, 0, 5'd0, '0, 0, 5'd0, '0, 0, 1);
   endtask

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: compares every cycle that has a pending expectation.
   initial begin
      logic [EXP_W-1:0] e, act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {bus.rdata_o[0], bus.rdata_o[1], bus.err_o, bus.wipe_busy_o, bus.wipe_done_o};
            n_vec++;
            if (act !== e) begin
               n_err++;
               $display("FAIL rf_cycle t=%0t actual rd0=%h rd1=%h err=%b busy=%b done=%b required rd0=%h rd1=%h err=%b busy=%b done=%b",
                        $time, act[EXP_W-1 -: DW], act[DW+2 : 3], act[2], act[1], act[0],
                        e[EXP_W-1 -: DW], e[DW+2 : 3], e[2], e[1], e[0]);
            end
         end
      end
   end

   initial begin
      int busy_cnt, done_cnt;
      bus.raddr_i = '0; bus.waddr_i = '0; bus.wdata_i = '0; bus.we_i = '0; bus.wipe_req_i = 1'b0;
      bus_e.raddr_i = '0; bus_e.waddr_i = '0; bus_e.wdata_i = '0; bus_e.we_i = '0; bus_e.wipe_req_i = 1'b0;
      m_pos = 0; m_err = 0;
      for (int i = 0; i < NW; i++) m_rf[i] = '0;
      @(posedge clk);
      #1;

      // Reset, then read every address on both ports.
      step(1, 5'd0, 5'd0, 0, 5'd0, '0, 0, 5'd0, '0, 0, 0);
      step(1, 5'd1, 5'd2, 0, 5'd0, '0, 0, 5'd0, '0, 0, 1);
      for (int i = 0; i < 16; i++) idle_read(5'(2 * i), 5'(2 * i + 1));

      // Single write, same-cycle and next-cycle read.
      step(0, 5'd5, 5'd5, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, '0, 0, 1);
      idle_read(5'd5, 5'd0);

      // Both ports write x7: port 1 wins, err next cycle only.
      step(0, 5'd7, 5'd5, 1, 5'd7, 32'h1111, 1, 5'd7, 32'h2222, 0, 1);
      idle_read(5'd7, 5'd5);
      idle_read(5'd7, 5'd0);

      // Both ports write x0: discarded, no error.
      step(0, 5'd0, 5'd7, 1, 5'd0, 32'h3333, 1, 5'd0, 32'h4444, 0, 1);
      idle_read(5'd0, 5'd7);
      idle_read(5'd0, 5'd0);

      // Random traffic with occasional wipe requests.
      for (int k = 0; k < 300; k++) begin
         step(0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 59) == 0), 1);
      end
      while (m_pos != 0) idle_read(5'd1, 5'd2);

      // Fill x1..x31 with their index, then wipe.
      for (int i = 1; i < NW; i++) step(0, 5'(i), 5'd0, 1, 5'(i), 32'(i), 0, 5'd0, '0, 0, 1);
      step(0, 5'd1, 5'd2, 0, 5'd0, '0, 0, 5'd0, '0, 1, 1);
      for (int j = 0; j < 34; j++) begin
         if (j == 1) step(0, 5'd3, 5'd4, 1, 5'd3, 32'hAA, 0, 5'd0, '0, 0, 1);
         else        idle_read(5'(j % 32), 5'((j + 16) % 32));
      end
      for (int i = 0; i < 16; i++) idle_read(5'(2 * i), 5'(2 * i + 1));

      // Reset in the middle of a wipe.
      for (int i = 1; i < 8; i++) step(0, 5'(i), 5'd0, 1, 5'(i), $urandom, 0, 5'd0, '0, 0, 1);
      step(0, 5'd1, 5'd2, 0, 5'd0, '0, 0, 5'd0, '0, 1, 1);
      for (int j = 0; j < 10; j++) idle_read(5'(j), 5'(j + 1));
      step(1, 5'd5, 5'd6, 0, 5'd0, '0, 0, 5'd0, '0, 0, 1);
      for (int i = 0; i < 16; i++) idle_read(5'(2 * i), 5'(2 * i + 1));
      for (int i = 0; i < 4; i++) idle_read(5'd0, 5'd0);

      @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL sb_drain actual=%0d required=0 pending", exp_q.size());
      end

      // RV32E instance: bit 4 ignored, 15-cycle wipe.
      @(posedge clk); #1;
      rst_e = 1'b0;
      bus_e.we_i = 2'b01; bus_e.waddr_i[0] = 5'h15; bus_e.wdata_i[0] = 32'h5555_AAAA;
      bus_e.raddr_i[0] = 5'd5; bus_e.raddr_i[1] = 5'h15;
      @(posedge clk); #1;
      bus_e.we_i = 2'b00;
      @(negedge clk);
      check("e_read_x5", bus_e.rdata_o[0], 32'h5555_AAAA);
      check("e_read_x15", bus_e.rdata_o[1], 32'h5555_AAAA);
      bus_e.raddr_i[1] = 5'h10;
      #1;
      check("e_read_x16_is_x0", bus_e.rdata_o[1], 32'h0);
      @(posedge clk); #1;
      bus_e.wipe_req_i = 1'b1;
      @(posedge clk); #1;
      bus_e.wipe_req_i = 1'b0;
      busy_cnt = 0; done_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus_e.wipe_busy_o) busy_cnt++;
         if (bus_e.wipe_done_o) done_cnt++;
      end
      check("e_busy_cycles", 32'(busy_cnt), 32'd15);
      check("e_done_pulses", 32'(done_cnt), 32'd1);
      check("e_x5_wiped", bus_e.rdata_o[0], 32'h0);
      check("e_err", 32'(bus_e.err_o), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
